// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO UART controller: register offsets within the
// 256-byte window and bit positions inside the STATUS register.
// Imported by the controller top level.
package mmio_pkg;

  // Register offsets from MMIO_BASE (low address byte)
  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RX_DATA = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_LEVELS  = 8'h0C;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTR   = 8'h14;
  localparam logic [7:0] OFF_CNT_CLR = 8'h18;

  // STATUS register bit positions
  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_TX_OVERFLOW  = 2;
  localparam int ST_RX_UNDERFLOW = 3;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head output and occupancy count.
// Ports: clk/rst (sync, active-high); push/din write side; pop/dout read side
// (dout is the current head); full/empty/count status. Push on full and pop
// on empty are ignored; no empty bypass, so a push into an empty FIFO is
// visible only from the next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only observable between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller between the CPU data port and the UART: buffered RX/TX
// FIFOs, sticky overflow/underflow flags, FIFO level readback and
// cycle/instruction counters in a 256-byte window at MMIO_BASE.
// Ports: clk/rst (sync, active-high); CPU side req/we/addr/wdata -> rdata
// (registered, one-cycle latency); inst_retire; UART RX valid/ready in,
// UART TX valid/ready out.
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          CNT_WIDTH = 32,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  // Decode
  logic       hit;
  logic       is_wr;
  logic [7:0] off;
  logic       rd_hit;
  logic       rd_rx;
  logic       wr_tx;
  logic       wr_status;
  logic       wr_cnt_clr;

  assign hit        = req && (addr[31:8] == MMIO_BASE[31:8]);
  assign is_wr      = |we;
  assign off        = addr[7:0];
  assign rd_hit     = hit && !is_wr;
  assign rd_rx      = rd_hit && (off == OFF_RX_DATA);
  assign wr_tx      = hit && is_wr && we[0] && (off == OFF_TX_DATA);
  assign wr_status  = hit && is_wr && (off == OFF_STATUS);
  assign wr_cnt_clr = hit && is_wr && (off == OFF_CNT_CLR);

  // FIFOs
  logic             rx_push;
  logic             rx_pop;
  logic [7:0]       rx_head;
  logic             rx_full;
  logic             rx_empty;
  logic [RX_CW-1:0] rx_count;

  logic             tx_push;
  logic             tx_pop;
  logic [7:0]       tx_head;
  logic             tx_full;
  logic             tx_empty;
  logic [TX_CW-1:0] tx_count;

  // rx_ready depends only on registered occupancy, never on a same-cycle pop
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_rx && !rx_empty;

  // Full check uses pre-drain occupancy, so a push onto a full FIFO is
  // dropped even when the transmitter drains an entry in the same cycle
  assign tx_push  = wr_tx && !tx_full;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (wdata[7:0]),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // Sticky error flags
  logic tx_overflow;
  logic rx_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else if (wr_status) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (wr_tx && tx_full)  tx_overflow  <= 1'b1;
      if (rd_rx && rx_empty) rx_underflow <= 1'b1;
    end
  end

  // Performance counters
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instr_cnt;

  always_ff @(posedge clk) begin
    if (rst || wr_cnt_clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (inst_retire) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
    end
  end

  // Read mux sees pre-update state, so reads return the value before this
  // cycle's pushes, pops, flag changes and counter increments
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STATUS: begin
        rd_val[ST_TX_NOT_FULL]  = !tx_full;
        rd_val[ST_RX_NOT_EMPTY] = !rx_empty;
        rd_val[ST_TX_OVERFLOW]  = tx_overflow;
        rd_val[ST_RX_UNDERFLOW] = rx_underflow;
      end
      OFF_RX_DATA: rd_val = rx_empty ? 32'h0 : {24'h0, rx_head};
      OFF_LEVELS:  rd_val = {16'(tx_count), 16'(rx_count)};
      OFF_CYCLE:   rd_val = 32'(cycle_cnt);
      OFF_INSTR:   rd_val = 32'(instr_cnt);
      default:     rd_val = '0;
    endcase
  end

  // rdata updates on read hits and on any miss; write hits leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (req && !hit) begin
      rdata <= '0;
    end else if (rd_hit) begin
      rdata <= rd_val;
    end
  end

  // Upper write-data bits are not used by any register
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
module tb_mmio_uart_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_STATUS  = BASE + 32'h00;
  localparam logic [31:0] A_RX      = BASE + 32'h04;
  localparam logic [31:0] A_TX      = BASE + 32'h08;
  localparam logic [31:0] A_LEVELS  = BASE + 32'h0C;
  localparam logic [31:0] A_CYCLE   = BASE + 32'h10;
  localparam logic [31:0] A_INSTR   = BASE + 32'h14;
  localparam logic [31:0] A_CNT_CLR = BASE + 32'h18;
  localparam logic [31:0] A_1C      = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        inst_retire;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(
    .RX_DEPTH (8),
    .TX_DEPTH (8),
    .CNT_WIDTH(32),
    .MMIO_BASE(BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .inst_retire(inst_retire),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t        rd_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] exp, input string nm);
    sb_t e;
    e.exp  = exp;
    e.name = nm;
    rd_q.push_back(e);
  endtask

  // Called at the negedge after the read was sampled: rdata is now valid
  task automatic sb_check();
    sb_t e;
    if (rd_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: read completed with no expectation queued");
    end else begin
      e = rd_q.pop_front();
      chk(e.name, rdata, e.exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    sb_push(exp, nm);
    bus(a, 4'h0, 32'h0);
    sb_check();
  endtask

  task automatic tx_wr(input logic [7:0] b, input logic accept);
    if (accept) tx_q.push_back(b);
    bus(A_TX, 4'hF, {24'hABCDEF, b});
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain_tx();
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && tx_q.size() != 0; i++) @(negedge clk);
    chk("tx_drained_left", 32'(tx_q.size()), 32'd0);
    chk("tx_valid_after_drain", {31'h0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
  endtask

  // TX scoreboard: every handshake must match the next accepted byte
  always @(posedge clk) begin : tx_mon
    logic [7:0] e;
    if (!rst && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got %h, expected no byte", tx_data);
      end else begin
        e = tx_q.pop_front();
        chk("tx_byte", {24'h0, tx_data}, {24'h0, e});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] cyc;
    rst = 1'b1; req = 1'b0; we = 4'h0; addr = '0; wdata = '0;
    inst_retire = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h99;   // offered during reset, must be refused

    // Table of simple register accesses after reset
    tbl.push_back('{A_STATUS, 4'h0, 32'h0,        32'h1, "status_after_reset"});
    tbl.push_back('{A_LEVELS, 4'h0, 32'h0,        32'h0, "levels_after_reset"});
    tbl.push_back('{A_1C,     4'h0, 32'h0,        32'h0, "read_off_1c"});
    tbl.push_back('{A_1C,     4'hF, 32'hFFFF_FFFF, 32'h0, "write_off_1c"});
    tbl.push_back('{A_STATUS, 4'h0, 32'h0,        32'h1, "status_before_miss"});
    tbl.push_back('{32'h0000_0000, 4'h0, 32'h0,   32'h0, "read_non_mmio"});
    tbl.push_back('{A_TX,     4'h2, 32'h55,       32'h0, "tx_write_no_we0"});
    tbl.push_back('{A_LEVELS, 4'h0, 32'h0,        32'h0, "levels_after_no_we0"});
    tbl.push_back('{A_RX,     4'h0, 32'h0,        32'h0, "rx_read_empty"});
    tbl.push_back('{A_STATUS, 4'h0, 32'h0,        32'h9, "status_underflow"});
    tbl.push_back('{A_STATUS, 4'h1, 32'h0,        32'h0, "status_clear"});
    tbl.push_back('{A_STATUS, 4'h0, 32'h0,        32'h1, "status_after_clear"});

    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
    rst = 1'b0; rx_valid = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we == 4'h0) rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
      else                   bus(tbl[i].addr, tbl[i].we, tbl[i].wdata);
    end

    // RX ordering and underflow
    rx_send(8'h41); rx_send(8'h42); rx_send(8'h43);
    rd(A_LEVELS, 32'h3, "levels_rx3");
    rd(A_RX, 32'h41, "rx_first");
    rd(A_RX, 32'h42, "rx_second");
    rd(A_RX, 32'h43, "rx_third");
    rd(A_RX, 32'h0, "rx_fourth_empty");
    rd(A_STATUS, 32'h9, "status_rx_underflow");
    bus(A_STATUS, 4'hF, 32'h0);

    // TX overflow with transmitter stalled
    for (int i = 0; i < 9; i++) tx_wr(8'(i), i < 8);
    rd(A_LEVELS, 32'h0008_0000, "levels_tx_full");
    rd(A_STATUS, 32'h4, "status_tx_overflow");
    drain_tx();
    bus(A_STATUS, 4'hF, 32'h0);
    rd(A_STATUS, 32'h1, "status_cleared_tx");

    // RX full: ready drops, stays low during the popping cycle, returns after
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h50;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rx_data = 8'(8'h50 + i);
    end
    chk("rx_ready_full", {31'h0, rx_ready}, 32'h0);
    @(negedge clk);
    chk("rx_ready_full_held", {31'h0, rx_ready}, 32'h0);
    req = 1'b1; we = 4'h0; addr = A_RX;
    sb_push(32'h50, "rx_pop_when_full");
    chk("rx_ready_pop_cycle", {31'h0, rx_ready}, 32'h0);
    @(negedge clk);
    req = 1'b0;
    sb_check();
    chk("rx_ready_after_pop", {31'h0, rx_ready}, 32'h1);
    @(negedge clk);
    rx_valid = 1'b0;
    rd(A_LEVELS, 32'h8, "levels_rx_refilled");
    rd(A_RX, 32'h51, "rx_0x51");
    // Simultaneous push and pop keeps the count
    @(negedge clk);
    req = 1'b1; we = 4'h0; addr = A_RX; rx_valid = 1'b1; rx_data = 8'h59;
    sb_push(32'h52, "rx_pop_with_push");
    @(negedge clk);
    req = 1'b0; rx_valid = 1'b0;
    sb_check();
    rd(A_LEVELS, 32'h7, "levels_push_pop");
    for (int i = 3; i <= 9; i++) rd(A_RX, 32'(8'h50 + i), "rx_drain_seq");
    rd(A_LEVELS, 32'h0, "levels_rx_empty");

    // No bypass: push and pop on an empty FIFO in one cycle
    @(negedge clk);
    req = 1'b1; we = 4'h0; addr = A_RX; rx_valid = 1'b1; rx_data = 8'h77;
    sb_push(32'h0, "rx_no_bypass");
    @(negedge clk);
    req = 1'b0; rx_valid = 1'b0;
    sb_check();
    rd(A_STATUS, 32'hB, "status_no_bypass");
    rd(A_RX, 32'h77, "rx_after_bypass");
    bus(A_STATUS, 4'hF, 32'h0);

    // TX full with same-cycle drain and push: push dropped, drain proceeds
    for (int i = 0; i < 8; i++) tx_wr(8'(8'hA0 + i), 1'b1);
    @(negedge clk);
    req = 1'b1; we = 4'h1; addr = A_TX; wdata = 32'hAA; tx_ready = 1'b1;
    @(negedge clk);
    req = 1'b0; we = 4'h0;
    rd(A_STATUS, 32'h5, "status_drop_on_drain");
    drain_tx();
    bus(A_STATUS, 4'hF, 32'h0);
    rd(A_STATUS, 32'h1, "status_cleared_drain");

    // Counters
    bus(A_CNT_CLR, 4'hF, 32'h0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      inst_retire = (i % 5) < 2;
    end
    @(negedge clk);
    inst_retire = 1'b0;
    rd(A_INSTR, 32'd40, "instr_40");
    sb_push(32'h0, "cycle_dummy");
    bus(A_CYCLE, 4'h0, 32'h0);
    cyc = rdata;
    void'(rd_q.pop_front());
    tests++;
    if (!(cyc >= 32'd100 && cyc <= 32'd110)) begin
      fails++;
      $display("FAIL cycle_ge_100: got %0d, expected 100..110", cyc);
    end
    bus(A_CNT_CLR, 4'hF, 32'h0);
    rd(A_CYCLE, 32'h1, "cycle_after_clr");
    rd(A_INSTR, 32'h0, "instr_after_clr");

    // Reset mid-transfer discards buffered bytes and flags
    rd(A_RX, 32'h0, "rx_underflow_pre_reset");
    rx_send(8'h22);
    tx_wr(8'h11, 1'b0);
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
    repeat (2) @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    chk("mid_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_reset_rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("mid_reset_rdata", rdata, 32'h0);
    rd(A_LEVELS, 32'h0, "levels_after_mid_reset");
    rd(A_STATUS, 32'h1, "status_after_mid_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
